universal_shift_register: RTL and testbench
===========================================

Name: universal_shift_register

Overview:
- Parametrised successor to the single-bit D flip-flop with clear/preset.
- WIDTH-bit register with synchronous clear, synchronous preset, hold, shift left, shift right and parallel load.
- Tracks shifts since the last load and flags when a full word has been serialised.
- Used as a serialiser/deserialiser and general storage element in the lab datapath.

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- PRESET_VAL, all ones (WIDTH bits), value loaded when PreN is asserted.
- CNT_W, $clog2(WIDTH+1), width of the shift counter (derived; not overridden).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- ClrN  input  1  synchronous active-low reset/clear.
- PreN  input  1  synchronous active-low preset.
- Mode  input  2  operation select: 00 hold, 01 shift left, 10 shift right, 11 parallel load.
- D  input  WIDTH  parallel load data.
- SIL  input  1  serial in, enters bit 0 on shift left.
- SIR  input  1  serial in, enters bit WIDTH-1 on shift right.
- Q  output  WIDTH  register contents.
- Q_bar  output  WIDTH  bitwise complement of Q, always.
- SOL  output  1  Q[WIDTH-1] (bit leaving on shift left).
- SOR  output  1  Q[0] (bit leaving on shift right).
- Count  output  CNT_W  shifts since last load/clear/preset, saturating at WIDTH.
- Done  output  1  high while Count == WIDTH.

Behaviour:
- Reset is fixed: one clock (CLK); reset is synchronous and active-low (ClrN). No asynchronous paths.
- Priority at each rising CLK edge: ClrN=0 > PreN=0 > Mode.
- ClrN=0: Q <= 0, Count <= 0, Done <= 0. This is the reset state: Q=0, Q_bar=all ones, SOL=0, SOR=0, Count=0, Done=0.
- ClrN=1, PreN=0: Q <= PRESET_VAL, Count <= 0.
- Mode 00 (hold): Q and Count unchanged.
- Mode 01 (shift left): Q <= {Q[WIDTH-2:0], SIL}; Count <= Count+1 unless Count == WIDTH.
- Mode 10 (shift right): Q <= {SIR, Q[WIDTH-1:1]}; Count increments the same way as shift left.
- Mode 11 (load): Q <= D; Count <= 0.
- Done is registered with Count, i.e. Done = (Count == WIDTH) after each edge. It goes high on the edge of the WIDTH-th shift after a load.
- Count saturates at WIDTH; further shifts keep Done=1 and still move data.
- Mixing left and right shifts counts each one; no direction tracking.
- Latency: every operation is visible on Q one cycle after the edge. Q_bar, SOL and SOR are combinational from Q.
- Reset or preset mid-serialisation aborts it: Count=0 and Done=0 on the next cycle.
- ClrN=0 and PreN=0 together: clear wins.
- X on Mode while ClrN=0: outputs still clear.

Optional Feature:
- Macro USR_ROTATE_EN.
- Defined: SIL/SIR are ignored for feedback purposes.
  - Shift left rotates: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
  - Shift right rotates: Q <= {Q[0], Q[WIDTH-1:1]}.
  - Count and Done behave as for shifts.
- Undefined: serial inputs as specified above. Port list is identical in both builds.

Decomposition:
- Package usr_pkg holds the 2-bit mode localparams MODE_HOLD=2'b00, MODE_SHL=2'b01, MODE_SHR=2'b10 and MODE_LOAD=2'b11.
- Sub-module usr_bit_cell: one bit with a 4:1 next-value mux plus a flop with synchronous clear/preset. It is instantiated WIDTH times via generate.
- The counter and Done logic live in the top.

Test Plan (WIDTH=8):
- ClrN=0 for 1 edge with D=8'hA5, Mode=11 -> Q=8'h00, Q_bar=8'hFF, Count=0, Done=0.
- ClrN=1, PreN=0 for 1 edge -> Q=8'hFF. Then PreN=1, Mode=00 for 3 edges -> Q stays 8'hFF, Count=0.
- Load D=8'hA5, then Mode=01 with SIL=0 for 8 edges -> SOL sequence 1,0,1,0,0,1,0,1. Final Q=8'h00, Count=8, Done=1 on the 8th edge. A 9th shift keeps Count=8.
- Mode=10, SIR driven 1,1,0,1,0,0,1,1 for 8 edges from Q=8'h00 -> Q=8'hCB, Done=1. Then load 8'h3C -> Q=8'h3C, Count=0, Done=0.
- Load 8'h81, shift left 4 edges, assert ClrN=0 with PreN=0 on the 5th edge -> Q=8'h00, Count=0, Done=0 (clear beats preset and aborts the shift).
- With USR_ROTATE_EN: load 8'h81, Mode=01 for 1 edge -> Q=8'h03. Mode=10 for 2 edges -> Q=8'hC0. Mode=01 for 8 total edges from 8'h81 -> Q=8'h81, Done=1.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operation-select encodings.
package usr_pkg;

  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_HOLD = 2'b00;
  localparam logic [MODE_W-1:0] MODE_SHL  = 2'b01;
  localparam logic [MODE_W-1:0] MODE_SHR  = 2'b10;
  localparam logic [MODE_W-1:0] MODE_LOAD = 2'b11;

  // True for either shift direction; both advance the shift counter.
  function automatic logic is_shift(input logic [MODE_W-1:0] mode);
    return (mode == MODE_SHL) || (mode == MODE_SHR);
  endfunction

endpackage : usr_pkg

// File: rtl/usr_bit_cell.sv
// One storage bit of the universal shift register: 4:1 next-value mux feeding
// a flop with synchronous clear (highest priority) and synchronous preset.
module usr_bit_cell
  import usr_pkg::*;
(
  input  logic              clk_i,
  input  logic              clr_n_i,
  input  logic              pre_n_i,
  input  logic              pre_val_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic              load_i,
  input  logic              shl_i,
  input  logic              shr_i,
  output logic              q_o
);

  logic q_q;
  logic q_d;

  // Next value selected by the operation mode.
  always_comb begin
    q_d = q_q;
    case (mode_i)
      MODE_HOLD: q_d = q_q;
      MODE_SHL:  q_d = shl_i;
      MODE_SHR:  q_d = shr_i;
      MODE_LOAD: q_d = load_i;
      default:   q_d = q_q;
    endcase
  end

  // Bit storage; clear beats preset beats the mode mux.
  always_ff @(posedge clk_i) begin
    if (!clr_n_i) begin
      q_q <= 1'b0;
    end else if (!pre_n_i) begin
      q_q <= pre_val_i;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule : usr_bit_cell

// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register (hold / shift left / shift right / load)
// with synchronous clear and preset, plus a saturating count of shifts since
// the last load/clear/preset and a Done flag once a full word has moved.
// Build option: define USR_ROTATE_EN to turn both shifts into rotates
// (serial inputs are then ignored; port list is unchanged).
module universal_shift_register
  import usr_pkg::*;
#(
  parameter  int unsigned           WIDTH      = 8,
  parameter  logic [WIDTH-1:0]      PRESET_VAL = '1,
  localparam int unsigned           CNT_W      = $clog2(WIDTH + 1)
) (
  input  logic              CLK,
  input  logic              ClrN,
  input  logic              PreN,
  input  logic [MODE_W-1:0] Mode,
  input  logic [WIDTH-1:0]  D,
  input  logic              SIL,
  input  logic              SIR,
  output logic [WIDTH-1:0]  Q,
  output logic [WIDTH-1:0]  Q_bar,
  output logic              SOL,
  output logic              SOR,
  output logic [CNT_W-1:0]  Count,
  output logic              Done
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  logic [WIDTH-1:0] q_w;
  logic             fb_left;
  logic             fb_right;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             done_q;
  logic             done_d;

`ifdef USR_ROTATE_EN
  // Rotate: the bit leaving one end re-enters the other.
  assign fb_left  = q_w[WIDTH-1];
  assign fb_right = q_w[0];

  logic unused_serial_in;
  assign unused_serial_in = SIL ^ SIR;
`else
  // Shift: serial inputs fill the vacated end.
  assign fb_left  = SIL;
  assign fb_right = SIR;
`endif

  // Bit slice array; each cell sees its lower neighbour for shift left and
  // its upper neighbour for shift right, with the ends fed by the feedback.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic shl_in;
    logic shr_in;

    if (i == 0) begin : g_lsb
      assign shl_in = fb_left;
    end else begin : g_mid_l
      assign shl_in = q_w[i-1];
    end

    if (i == WIDTH - 1) begin : g_msb
      assign shr_in = fb_right;
    end else begin : g_mid_r
      assign shr_in = q_w[i+1];
    end

    usr_bit_cell u_cell (
      .clk_i     (CLK),
      .clr_n_i   (ClrN),
      .pre_n_i   (PreN),
      .pre_val_i (PRESET_VAL[i]),
      .mode_i    (Mode),
      .load_i    (D[i]),
      .shl_i     (shl_in),
      .shr_i     (shr_in),
      .q_o       (q_w[i])
    );
  end

  // Shift counter next state: loads restart it, shifts advance it up to full.
  always_comb begin
    count_d = count_q;
    if (Mode == MODE_LOAD) begin
      count_d = '0;
    end else if (is_shift(Mode) && (count_q != CNT_FULL)) begin
      count_d = count_q + CNT_W'(1);
    end
    done_d = (count_d == CNT_FULL);
  end

  // Counter and Done registers; clear or preset abort any serialisation.
  always_ff @(posedge CLK) begin
    if (!ClrN || !PreN) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign Q     = q_w;
  assign Q_bar = ~q_w;
  assign SOL   = q_w[WIDTH-1];
  assign SOR   = q_w[0];
  assign Count = count_q;
  assign Done  = done_q;

endmodule : universal_shift_register

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register (WIDTH=8) with an arithmetic
// reference model checked every cycle and hand-computed literal checkpoints.
module tb_universal_shift_register;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = $clog2(W + 1);
`ifdef USR_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          ClrN = 1'b1;
  logic          PreN = 1'b1;
  logic [1:0]    Mode = 2'b00;
  logic [W-1:0]  D = '0;
  logic          SIL = 1'b0;
  logic          SIR = 1'b0;
  logic [W-1:0]  Q;
  logic [W-1:0]  Q_bar;
  logic          SOL;
  logic          SOR;
  logic [CW-1:0] Count;
  logic          Done;

  universal_shift_register #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .ClrN  (ClrN),
    .PreN  (PreN),
    .Mode  (Mode),
    .D     (D),
    .SIL   (SIL),
    .SIR   (SIR),
    .Q     (Q),
    .Q_bar (Q_bar),
    .SOL   (SOL),
    .SOR   (SOR),
    .Count (Count),
    .Done  (Done)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: register value as an integer 0..255, shift count 0..8.
  int m_q     = 0;
  int m_cnt   = 0;
  bit m_valid = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit clr_n, input bit pre_n, input int mode,
                            input int d, input bit sil, input bit sir);
    int fill;
    if (!clr_n) begin
      m_q = 0;   m_cnt = 0;
    end else if (!pre_n) begin
      m_q = 255; m_cnt = 0;
    end else begin
      case (mode)
        1: begin
          fill  = ROT ? (m_q / 128) : int'(sil);
          m_q   = (m_q * 2) % 256 + fill;
          m_cnt = (m_cnt < 8) ? m_cnt + 1 : 8;
        end
        2: begin
          fill  = ROT ? (m_q % 2) : int'(sir);
          m_q   = m_q / 2 + 128 * fill;
          m_cnt = (m_cnt < 8) ? m_cnt + 1 : 8;
        end
        3: begin
          m_q = d; m_cnt = 0;
        end
        default: ;
      endcase
    end
  endtask

  // Apply one set of inputs across one rising edge and advance the model.
  task automatic cyc(input bit clr_n, input bit pre_n, input logic [1:0] mode,
                     input logic [7:0] d, input bit sil, input bit sir);
    ClrN = clr_n; PreN = pre_n; Mode = mode; D = d; SIL = sil; SIR = sir;
    @(posedge CLK);
    model_step(clr_n, pre_n, int'(mode), int'(d), sil, sir);
    if (!clr_n) m_valid = 1'b1;
    #1;
  endtask

  // Every-cycle comparison against the model, sampled mid-period.
  always @(negedge CLK) begin
    if (m_valid) begin
      chk("model_Q",     int'(Q),     m_q);
      chk("model_Q_bar", int'(Q_bar), 255 - m_q);
      chk("model_SOL",   int'(SOL),   m_q / 128);
      chk("model_SOR",   int'(SOR),   m_q % 2);
      chk("model_Count", int'(Count), m_cnt);
      chk("model_Done",  int'(Done),  (m_cnt == 8) ? 1 : 0);
    end
  end

  logic [7:0] sol_exp;
  logic [7:0] sir_seq;

  initial begin
    sol_exp = 8'b1010_0101;
    sir_seq = 8'b1101_0011;
    @(posedge CLK); #1;

    // Clear with load pending and unknown-free data: clear wins.
    cyc(1'b0, 1'b1, 2'b11, 8'hA5, 1'b0, 1'b0);
    chk("rst_Q", int'(Q), 'h00);
    chk("rst_Q_bar", int'(Q_bar), 'hFF);
    chk("rst_Count", int'(Count), 0);
    chk("rst_Done", int'(Done), 0);
    chk("rst_SOL_SOR", int'({SOL, SOR}), 0);

    // Clear with Mode undriven.
    cyc(1'b0, 1'b1, 2'bxx, 8'h5A, 1'b1, 1'b1);
    chk("rst_xmode_Q", int'(Q), 'h00);

    // Preset, then hold.
    cyc(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
    chk("preset_Q", int'(Q), 'hFF);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 2'b00, 8'h12, 1'b1, 1'b1);
    chk("hold_Q", int'(Q), 'hFF);
    chk("hold_Count", int'(Count), 0);

    // Load A5 and serialise out to the left.
    cyc(1'b1, 1'b1, 2'b11, 8'hA5, 1'b0, 1'b0);
    chk("load_Q", int'(Q), 'hA5);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("sol_seq%0d", i), int'(SOL), int'(sol_exp[7-i]));
      if (i == 7) chk("done_before_8th", int'(Done), 0);
      cyc(1'b1, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0);
    end
`ifndef USR_ROTATE_EN
    chk("shl8_Q", int'(Q), 'h00);
`else
    chk("rotl8_Q", int'(Q), 'hA5);
`endif
    chk("shl8_Count", int'(Count), 8);
    chk("shl8_Done", int'(Done), 1);
    cyc(1'b1, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0);
    chk("shl9_Count", int'(Count), 8);
    chk("shl9_Done", int'(Done), 1);

    // Deserialise from the right.
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 2'b10, 8'h00, 1'b0, sir_seq[7-i]);
`ifndef USR_ROTATE_EN
    chk("shr8_Q", int'(Q), 'hCB);
`endif
    chk("shr8_Done", int'(Done), 1);
    cyc(1'b1, 1'b1, 2'b11, 8'h3C, 1'b0, 1'b0);
    chk("reload_Q", int'(Q), 'h3C);
    chk("reload_Count", int'(Count), 0);
    chk("reload_Done", int'(Done), 0);

    // Clear together with preset mid-serialisation.
    cyc(1'b1, 1'b1, 2'b11, 8'h81, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0);
    chk("mid_Count", int'(Count), 4);
    cyc(1'b0, 1'b0, 2'b01, 8'h00, 1'b1, 1'b0);
    chk("abort_clr_Q", int'(Q), 'h00);
    chk("abort_clr_Count", int'(Count), 0);
    chk("abort_clr_Done", int'(Done), 0);

    // Preset mid-serialisation after Done was reached.
    cyc(1'b1, 1'b1, 2'b11, 8'h0F, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, 8'h00, 1'b1, 1'b0);
    chk("mixed_Done", int'(Done), 1);
    cyc(1'b1, 1'b0, 2'b10, 8'h00, 1'b0, 1'b0);
    chk("abort_pre_Q", int'(Q), 'hFF);
    chk("abort_pre_Count", int'(Count), 0);
    chk("abort_pre_Done", int'(Done), 0);

    // Rotate-sensitive sequence from 81.
    cyc(1'b1, 1'b1, 2'b11, 8'h81, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0);
`ifdef USR_ROTATE_EN
    chk("rot_l1_Q", int'(Q), 'h03);
`else
    chk("shl1_Q", int'(Q), 'h02);
`endif
    cyc(1'b1, 1'b1, 2'b10, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 2'b10, 8'h00, 1'b0, 1'b0);
`ifdef USR_ROTATE_EN
    chk("rot_r2_Q", int'(Q), 'hC0);
`else
    chk("shr2_Q", int'(Q), 'h00);
`endif
    cyc(1'b1, 1'b1, 2'b11, 8'h81, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0);
`ifdef USR_ROTATE_EN
    chk("rot_l8_Q", int'(Q), 'h81);
`else
    chk("shl8b_Q", int'(Q), 'h00);
`endif
    chk("l8_Done", int'(Done), 1);

    // Mixed pseudo-random traffic, checked by the model only.
    for (int i = 0; i < 200; i++) begin
      cyc(($urandom_range(0, 19) != 0), ($urandom_range(0, 14) != 0),
          2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    @(negedge CLK);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_universal_shift_register
